// File: rtl/mem_test_ctrl.sv
// mem_test_ctrl: memory self-test controller with manual access and automatic fill/verify sweeps
module mem_test_ctrl #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 6,
    parameter logic [31:0] PAT0   = 32'h11223344,
    parameter logic [31:0] PAT1   = 32'h44332211
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        pat_s,
    input  logic              man_we,
    input  logic [ADDR_W-1:0] man_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

    localparam int           DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] s, input logic [ADDR_W-1:0] a);
        return s == 2'd0 ? DATA_W'(PAT0) : s == 2'd1 ? DATA_W'(PAT1) :
               s == 2'd2 ? DATA_W'(a) : ~DATA_W'(a);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, a_d_q, man_addr_q;
    logic [1:0]        mode_q, pat_q;
    logic [ADDR_W:0]   err_cnt_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic              pass_q, vld_q, show_err_q;
    logic [DATA_W-1:0] rd_q;

    logic              launch, wr_en, miss;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    assign launch  = state_q == S_IDLE && start && mode != 2'b00;
    assign wr_en   = (state_q == S_IDLE && mode == 2'b00 && man_we) || state_q == S_FILL;
    assign wr_addr = state_q == S_FILL ? addr_q : man_addr;
    assign wr_data = pat(state_q == S_FILL ? pat_q : pat_s, wr_addr);
    assign rd_addr = state_q == S_VERIFY ? addr_q : man_addr;
    assign miss    = vld_q && rd_q != pat(pat_q, a_d_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = !launch ? S_IDLE : mode == 2'b10 ? S_VERIFY : S_FILL;
            S_FILL:   state_d = addr_q != '1 ? S_FILL : mode_q == 2'b11 ? S_VERIFY : S_DONE;
            S_VERIFY: state_d = addr_q == '1 ? S_DRAIN : S_VERIFY;
            S_DRAIN:  state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            a_d_q       <= '0;
            man_addr_q  <= '0;
            mode_q      <= '0;
            pat_q       <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
            vld_q       <= 1'b0;
            show_err_q  <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q    <= state_d;
            a_d_q      <= addr_q;
            vld_q      <= state_q == S_VERIFY;
            rd_q       <= mem[rd_addr];
            man_addr_q <= man_addr;
            if (launch) begin
                mode_q      <= mode;
                pat_q       <= pat_s;
                err_cnt_q   <= '0;
                fail_addr_q <= '0;
                pass_q      <= 1'b0;
                addr_q      <= '0;
            end else if (state_q == S_FILL || state_q == S_VERIFY) begin
                addr_q <= addr_q + 1'b1;
            end
            if (miss) begin
                if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
                if (err_cnt_q == '0) fail_addr_q <= a_d_q;
            end
            // error count stays on the display until the operator touches the manual controls
            if (state_q == S_DRAIN) show_err_q <= 1'b1;
            else if (launch || (state_q == S_IDLE && (man_we || man_addr != man_addr_q))) show_err_q <= 1'b0;
            if (state_q == S_DONE && err_cnt_q == '0) pass_q <= 1'b1;
        end
    end

    assign busy      = state_q == S_FILL || state_q == S_VERIFY || state_q == S_DRAIN;
    assign done      = state_q == S_DONE;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign disp_data = show_err_q ? DATA_W'(err_cnt_q) : state_q == S_FILL ? wr_data : rd_q;
endmodule

// File: tb/tb_mem_test_ctrl.sv
// tb_mem_test_ctrl: directed checks of manual access, fill/verify sweeps, busy protection and reset
module tb_mem_test_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, man_we;
    logic [1:0]  mode, pat_s;
    logic [5:0]  man_addr;
    logic [31:0] disp_data;
    logic        busy, done, pass;
    logic [6:0]  err_cnt;
    logic [5:0]  fail_addr;
    int          checks = 0;
    int          failures = 0;

    mem_test_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_s(pat_s),
        .man_we(man_we), .man_addr(man_addr), .disp_data(disp_data),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // inj 1: start/man_we pulse at cycle 10; inj 2: reset at cycle 20 then abort
    task automatic run(input logic [1:0] m, input logic [1:0] p, input int exp_len, input int inj);
        int k;
        mode = m;
        pat_s = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        chk("busy_on", busy, 1);
        while (!done && k < 400) begin
            if (inj == 1 && k == 10) begin
                start = 1'b1;
                man_we = 1'b1;
                mode = 2'b11;
                man_addr = 6'd3;
                pat_s = 2'b01;
            end
            if (inj == 2 && k == 20) begin
                rst = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_err", err_cnt, 0);
                chk("rst_disp", disp_data, 0);
                tick();
                rst = 1'b1;
                tick();
                return;
            end
            tick();
            start = 1'b0;
            man_we = 1'b0;
            k++;
        end
        chk("run_len", k, exp_len);
        chk("busy_off", busy, 0);
        tick();
    endtask

    initial begin
        int ndone;
        rst = 1'b0; start = 1'b0; man_we = 1'b0; mode = 2'b00; pat_s = 2'b00; man_addr = '0;
        repeat (2) tick();
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_pass0", pass, 0);
        chk("rst_err0", err_cnt, 0);
        chk("rst_fail0", fail_addr, 0);
        chk("rst_disp0", disp_data, 0);
        rst = 1'b1;
        tick();

        run(2'b11, 2'b00, 130, 0);
        chk("fv_err", err_cnt, 0);
        chk("fv_pass", pass, 1);
        chk("fv_fail", fail_addr, 0);

        run(2'b01, 2'b10, 65, 0);
        chk("fill_pass", pass, 1);
        run(2'b10, 2'b11, 66, 0);
        chk("mis_err", err_cnt, 64);
        chk("mis_fail", fail_addr, 0);
        chk("mis_pass", pass, 0);

        run(2'b01, 2'b00, 65, 0);
        mode = 2'b00; pat_s = 2'b01; man_addr = 6'd37; man_we = 1'b1;
        tick();
        man_we = 1'b0;
        run(2'b10, 2'b00, 66, 0);
        chk("one_err", err_cnt, 1);
        chk("one_fail", fail_addr, 37);
        chk("one_disp", disp_data, 1);
        chk("one_pass", pass, 0);
        tick();
        chk("one_hold", disp_data, 1);

        mode = 2'b00; pat_s = 2'b01; man_addr = 6'd5; man_we = 1'b1;
        tick();
        man_we = 1'b0;
        chk("man_old", disp_data, 32'h11223344);
        tick();
        chk("man_new", disp_data, 32'h44332211);

        run(2'b01, 2'b10, 65, 1);
        ndone = 0;
        repeat (5) begin
            if (done) ndone++;
            tick();
        end
        chk("bp_extra_done", ndone, 0);
        mode = 2'b00;
        man_addr = 6'd3;
        tick();
        tick();
        chk("bp_mem3", disp_data, 3);
        run(2'b10, 2'b10, 66, 0);
        chk("bp_err", err_cnt, 0);
        chk("bp_pass", pass, 1);

        run(2'b10, 2'b11, 66, 2);
        chk("rst_pass", pass, 0);
        run(2'b10, 2'b10, 66, 0);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
